// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the RISC-V front end.
//   op_e        - decoded operation class
//   idu_t       - decoded instruction handed from decode to issue
//   isu_state_e - issue-stage control state
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int SEQ_W = 64;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ADDI,
        OP_ADD,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JAL,
        OP_FENCE
    } op_e;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  addr_next;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [XLEN-1:0]  immed;
        op_e              op;
        logic [XLEN-1:0]  data;
    } idu_t;

    typedef enum logic {
        IDLE,
        WAIT
    } isu_state_e;

endpackage

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32 x 32-bit architectural register file.
//   clock, reset     - clock and synchronous active-high reset (clears all registers)
//   we/waddr/wdata   - single write port, writes to x0 are discarded
//   raddr1/rdata1    - asynchronous read port 1
//   raddr2/rdata2    - asynchronous read port 2
// A write in progress is forwarded to a matching read in the same cycle,
// so callers always see the value that will exist after this edge.
module riscv_regfile
    import riscv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/riscv_isu.sv
// riscv_isu: in-order issue stage feeding the execute control stage.
//   clock, reset            - clock and synchronous active-high reset
//   in_vld/in_rdy/in_idu    - decoded instruction input (FIFO push side)
//   exu_vld/exu_idu         - registered one-cycle issue strobe and instruction
//   exu_rs1_data/rs2_data   - registered source operands
//   exu_done                - execute finished the outstanding instruction
//   wb_en/wb_rd/wb_data     - register writeback, qualified by exu_done
//   flush/flush_seq         - discard every instruction with seq >= flush_seq
//   hang                    - one-cycle pulse when execute never answered
module riscv_isu
    import riscv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int HANG_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  idu_t             in_idu,
    output logic             exu_vld,
    output idu_t             exu_idu,
    output logic [XLEN-1:0]  exu_rs1_data,
    output logic [XLEN-1:0]  exu_rs2_data,
    input  logic             exu_done,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic [SEQ_W-1:0] flush_seq,
    output logic             hang
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HANG_W = $clog2(HANG_LIMIT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_LIMIT - 1);

    idu_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   kept;
    logic [PTR_W-1:0]   wr_addr;
    logic               push;
    logic               fifo_pop;
    logic               hang_expire;
    logic               wb_we;
    idu_t               head;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    isu_state_e         state;
    isu_state_e         state_nxt;
    logic [HANG_W-1:0]  hang_cnt;

    assign in_rdy = (count < DEPTH_C) && !reset;
    // A push racing a flush survives only if it is older than the redirect.
    assign push   = in_vld && in_rdy && !(flush && (in_idu.seq >= flush_seq));
    assign head   = mem[rd_ptr];
    assign wb_we  = wb_en && exu_done;

    riscv_regfile u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (head.rs1),
        .raddr2 (head.rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Entries are in seq order, so the survivors of a flush are the leading
    // run of entries (from the head) whose seq is below flush_seq.
    always_comb begin
        logic stop;
        kept = '0;
        stop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!stop && (CNT_W'(i) < count) &&
                (mem[rd_ptr + PTR_W'(i)].seq < flush_seq)) begin
                kept = kept + 1'b1;
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign wr_addr = flush ? (rd_ptr + kept[PTR_W-1:0]) : wr_ptr;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_addr] <= in_idu;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= wr_addr + PTR_W'(push);
            count  <= kept + CNT_W'(push);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fifo_pop) state_nxt = WAIT;
            WAIT: if (exu_done || flush || hang_expire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop    = 1'b0;
        hang_expire = 1'b0;
        case (state)
            IDLE: fifo_pop = (count != '0) && !flush;
            WAIT: hang_expire = !exu_done && !flush && (hang_cnt == HANG_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || (state_nxt != WAIT) || (state != WAIT)) begin
            hang_cnt <= '0;
        end else begin
            hang_cnt <= hang_cnt + 1'b1;
        end
    end

    // Issue stage boundary: operands and instruction are captured on pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            exu_vld      <= 1'b0;
            exu_idu      <= '0;
            exu_rs1_data <= '0;
            exu_rs2_data <= '0;
            hang         <= 1'b0;
        end else begin
            exu_vld <= fifo_pop;
            hang    <= hang_expire;
            if (fifo_pop) begin
                exu_idu      <= head;
                exu_rs1_data <= rs1_data;
                exu_rs2_data <= rs2_data;
            end
        end
    end

endmodule
